piso_serializer: RTL

//   Parallel-in/serial-out stage feeding the sequence-detector FSMs.

---
 rtl/piso_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in/serial-out stage that feeds the sequence-detector FSMs.
//   Accepts WIDTH-bit words over a valid/ready handshake and drives one bit per
//   clk on x. A one-word holding register lets consecutive words stream with
//   no idle gap. A 16-bit counter records completed words.
// Parameters
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level on x while nothing is being shifted
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   din        parallel word, sampled on accept
//   din_valid  upstream offers din
//   din_ready  holding register free and not in reset
//   x          serial bit (shreg head in SHIFT, IDLE_BIT otherwise)
//   x_valid    x carries a data bit
//   busy       x_valid | hold_full
//   word_cnt   fully transmitted words, wraps silently
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [15:0]      word_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] hold, hold_nx;
    logic             hold_full, hold_full_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [15:0]      word_cnt_nx;
    logic [WIDTH-1:0] shifted;
    logic             head;
    logic             accept;
    logic             last_bit;

    // din_ready depends only on state and rst, so din/din_valid never reach
    // an output combinationally.
    assign din_ready = ~hold_full & ~rst;
    assign accept    = din_valid & din_ready;
    assign last_bit  = (state == SHIFT) && (cnt == LAST);

    assign head    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    assign x_valid = (state == SHIFT);
    assign x       = x_valid ? head : IDLE_BIT;
    assign busy    = x_valid | hold_full;

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        cnt_nx       = cnt;
        word_cnt_nx  = word_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nx = din;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nx = shifted;
                cnt_nx   = cnt + 1'b1;
                if (last_bit) begin
                    word_cnt_nx = word_cnt + 16'd1;
                    // Held word wins over a new offer; hold_full also blocks
                    // accept here, so the two never collide.
                    if (hold_full) begin
                        shreg_nx     = hold;
                        hold_full_nx = 1'b0;
                        cnt_nx       = '0;
                    end else if (accept) begin
                        shreg_nx = din;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (accept) begin
                    hold_nx      = din;
                    hold_full_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            hold_full <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shreg     <= shreg_nx;
            hold_full <= hold_full_nx;
            word_cnt  <= word_cnt_nx;
        end
    end

    // Payload only; hold_full qualifies it.
    always_ff @(posedge clk) begin
        hold <= hold_nx;
    end
endmodule
